// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired control unit for the single-bus CPU datapath. A one-state-per-
//   clock FSM walks through instruction fetch (T0-T2) and per-opcode execute
//   steps (T3-T7), with PAUSE (Stop at an instruction boundary) and an
//   absorbing HALT state. All strobes are a combinational decode of the
//   state register and the live IR opcode.
//
// Ports
//   Clock            system clock, rising edge active
//   Clear            asynchronous active-low reset
//   opcode[4:0]      IR[31:27] from the datapath
//   Stop             pause request, honoured at the last step of an instruction
//   PCout..Rout      bus-drive strobes (at most one active at a time)
//   MARin..InPortIn  register-load strobes
//   IncPC, Read      PC increment, memory read
//   GRA, GRB, GRC    register-field selects
//   ALUsel[3:0]      ALU function (0 ADD, 1 SUB, 2 AND, 3 OR), 0 when unused
//   Run              high in T0..T7
//   step[3:0]        current state code
module control_sequencer (
    input  logic       Clock,
    input  logic       Clear,
    input  logic [4:0] opcode,
    input  logic       Stop,
    output logic       PCout,
    output logic       ZLowout,
    output logic       ZHighout,
    output logic       MDRout,
    output logic       HIout,
    output logic       LOout,
    output logic       Cout,
    output logic       InPortOut,
    output logic       BAout,
    output logic       Rout,
    output logic       MARin,
    output logic       MDRin,
    output logic       PCin,
    output logic       IRin,
    output logic       Yin,
    output logic       ZLowIn,
    output logic       ZHighIn,
    output logic       HIin,
    output logic       LOin,
    output logic       CONin,
    output logic       Rin,
    output logic       RAMin,
    output logic       OutPortIn,
    output logic       InPortIn,
    output logic       IncPC,
    output logic       Read,
    output logic       GRA,
    output logic       GRB,
    output logic       GRC,
    output logic [3:0] ALUsel,
    output logic       Run,
    output logic [3:0] step
);

    typedef enum logic [3:0] {
        S_RST   = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_PAUSE = 4'd9,
        S_HALT  = 4'd10
    } state_e;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_HALT = 5'b11001;

    state_e state_q, state_d;
    logic   last_step;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Final execute step of the current instruction class. Using >= keeps the
    // FSM from running past T7 into PAUSE if the opcode ever misbehaves.
    always_comb begin
        last_step = 1'b0;
        case (opcode)
            OP_LD, OP_ST:                       last_step = (state_q == S_T7);
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR: last_step = (state_q >= S_T5);
            default:                            last_step = (state_q >= S_T3);
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST: state_d = S_T0;
            S_T0:  state_d = S_T1;
            S_T1:  state_d = S_T2;
            S_T2:  state_d = S_T3;
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (last_step) begin
                    // halt takes priority over a pending pause request
                    if (opcode == OP_HALT) begin
                        state_d = S_HALT;
                    end else if (Stop) begin
                        state_d = S_PAUSE;
                    end else begin
                        state_d = S_T0;
                    end
                end else begin
                    state_d = state_e'(state_q + 4'd1);
                end
            end
            S_PAUSE: state_d = Stop ? S_PAUSE : S_T0;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        PCout     = 1'b0;
        ZLowout   = 1'b0;
        ZHighout  = 1'b0;
        MDRout    = 1'b0;
        HIout     = 1'b0;
        LOout     = 1'b0;
        Cout      = 1'b0;
        InPortOut = 1'b0;
        BAout     = 1'b0;
        Rout      = 1'b0;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        PCin      = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        ZLowIn    = 1'b0;
        ZHighIn   = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        CONin     = 1'b0;
        Rin       = 1'b0;
        RAMin     = 1'b0;
        OutPortIn = 1'b0;
        InPortIn  = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        GRA       = 1'b0;
        GRB       = 1'b0;
        GRC       = 1'b0;
        ALUsel    = 4'd0;
        Run       = (state_q >= S_T0) && (state_q <= S_T7);
        step      = state_q;

        // Fetch steps ignore opcode: IR is only updated at the end of T2.
        case (state_q)
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                ZLowIn = 1'b1;
            end
            S_T1: begin
                ZLowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                case (opcode)
                    OP_LD, OP_LDI, OP_ST: begin
                        GRB   = 1'b1;
                        BAout = 1'b1;
                        Yin   = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        GRB  = 1'b1;
                        Rout = 1'b1;
                        Yin  = 1'b1;
                    end
                    OP_IN: begin
                        InPortOut = 1'b1;
                        GRA       = 1'b1;
                        Rin       = 1'b1;
                    end
                    OP_OUT: begin
                        GRA       = 1'b1;
                        Rout      = 1'b1;
                        OutPortIn = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (opcode)
                    // effective address: Y (base) + C (offset), ALU forced to ADD
                    OP_LD, OP_LDI, OP_ST: begin
                        Cout   = 1'b1;
                        ZLowIn = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        GRC    = 1'b1;
                        Rout   = 1'b1;
                        ZLowIn = 1'b1;
                        ALUsel = {1'b0, opcode[2:0]} - 4'd3;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (opcode)
                    OP_LD, OP_ST: begin
                        ZLowout = 1'b1;
                        MARin   = 1'b1;
                    end
                    OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        ZLowout = 1'b1;
                        GRA     = 1'b1;
                        Rin     = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (opcode)
                    OP_LD: begin
                        Read  = 1'b1;
                        MDRin = 1'b1;
                    end
                    OP_ST: begin
                        GRA   = 1'b1;
                        Rout  = 1'b1;
                        MDRin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (opcode)
                    OP_LD: begin
                        MDRout = 1'b1;
                        GRA    = 1'b1;
                        Rin    = 1'b1;
                    end
                    OP_ST: begin
                        MDRout = 1'b1;
                        RAMin  = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Single-bus datapath: two drivers on the bus at once would be a short.
    assert property (@(posedge Clock) disable iff (!Clear)
        $onehot0({PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout,
                  InPortOut, BAout, Rout}));

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic       Clock = 1'b0;
    logic       Clear = 1'b1;
    logic       Stop  = 1'b0;
    logic [4:0] opcode;
    logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortOut, BAout, Rout;
    logic MARin, MDRin, PCin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, CONin, Rin, RAMin;
    logic OutPortIn, InPortIn, IncPC, Read, GRA, GRB, GRC, Run;
    logic [3:0] ALUsel, step;

    control_sequencer dut (
        .Clock(Clock), .Clear(Clear), .opcode(opcode), .Stop(Stop),
        .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortOut(InPortOut),
        .BAout(BAout), .Rout(Rout), .MARin(MARin), .MDRin(MDRin), .PCin(PCin),
        .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin),
        .LOin(LOin), .CONin(CONin), .Rin(Rin), .RAMin(RAMin),
        .OutPortIn(OutPortIn), .InPortIn(InPortIn), .IncPC(IncPC), .Read(Read),
        .GRA(GRA), .GRB(GRB), .GRC(GRC), .ALUsel(ALUsel), .Run(Run), .step(step)
    );

    always #5 Clock = ~Clock;

    // Strobe vector, MSB first in this order.
    logic [28:0] act_vec;
    assign act_vec = {PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortOut,
                      BAout, Rout, MARin, MDRin, PCin, IRin, Yin, ZLowIn, ZHighIn, HIin,
                      LOin, CONin, Rin, RAMin, OutPortIn, InPortIn, IncPC, Read, GRA,
                      GRB, GRC};

    localparam logic [28:0] PCOUT = 29'd1 << 28, ZLOWOUT = 29'd1 << 27, MDROUT = 29'd1 << 25;
    localparam logic [28:0] COUT = 29'd1 << 22, INPORTOUT = 29'd1 << 21, BAOUT = 29'd1 << 20;
    localparam logic [28:0] ROUT = 29'd1 << 19, MARIN = 29'd1 << 18, MDRIN = 29'd1 << 17;
    localparam logic [28:0] PCIN = 29'd1 << 16, IRIN = 29'd1 << 15, YIN = 29'd1 << 14;
    localparam logic [28:0] ZLOWIN = 29'd1 << 13, RIN = 29'd1 << 8, RAMIN = 29'd1 << 7;
    localparam logic [28:0] OUTPORTIN = 29'd1 << 6, INCPC = 29'd1 << 4, READ = 29'd1 << 3;
    localparam logic [28:0] GRA_M = 29'd1 << 2, GRB_M = 29'd1 << 1, GRC_M = 29'd1;

    localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010, ADD = 5'b00011;
    localparam logic [4:0] SUB = 5'b00100, AND_OP = 5'b00101, OR_OP = 5'b00110;
    localparam logic [4:0] IN_OP = 5'b10110, OUT_OP = 5'b10111, NOP = 5'b11000, HALT = 5'b11001;

    localparam int C_LD = 0, C_LDI = 1, C_ST = 2, C_ALU = 3, C_IN = 4, C_OUT = 5, C_NOP = 6;
    localparam int M_RST = 0, M_RUN = 1, M_PAUSE = 2, M_HALT = 3;

    // Instruction-level model: each class is a list of strobe sets, one per
    // execute cycle after the common 3-cycle fetch.
    logic [28:0] fet [0:2];
    logic [28:0] tbl [0:6][0:4];

    function automatic int cls_of(input logic [4:0] op);
        case (op)
            LD:                         return C_LD;
            LDI:                        return C_LDI;
            ST:                         return C_ST;
            ADD, SUB, AND_OP, OR_OP:    return C_ALU;
            IN_OP:                      return C_IN;
            OUT_OP:                     return C_OUT;
            default:                    return C_NOP;
        endcase
    endfunction

    function automatic int len_of(input int c);
        if (c == C_LD || c == C_ST) return 8;
        if (c == C_LDI || c == C_ALU) return 6;
        return 4;
    endfunction

    int         checks = 0;
    int         errors = 0;
    int         m_mode = M_RST;
    int         m_idx  = 0;
    logic [4:0] ir     = 5'b11111;
    logic [4:0] q[$];
    bit         cmp_en = 1'b0;

    assign opcode = ir;

    // Model: instruction position counter plus the IR it fetched.
    always @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            m_mode <= M_RST;
            m_idx  <= 0;
        end else begin
            case (m_mode)
                M_RST: begin
                    m_mode <= M_RUN;
                    m_idx  <= 0;
                end
                M_RUN: begin
                    if (m_idx < 2) begin
                        m_idx <= m_idx + 1;
                    end else if (m_idx == 2) begin
                        m_idx <= 3;
                        if (q.size() > 0) ir <= q.pop_front();
                        else              ir <= NOP;
                    end else if (m_idx == len_of(cls_of(ir)) - 1) begin
                        if (ir == HALT)  m_mode <= M_HALT;
                        else if (Stop)   m_mode <= M_PAUSE;
                        else             m_idx  <= 0;
                    end else begin
                        m_idx <= m_idx + 1;
                    end
                end
                M_PAUSE: if (!Stop) begin
                    m_mode <= M_RUN;
                    m_idx  <= 0;
                end
                default: ;
            endcase
        end
    end

    function automatic int exp_step();
        case (m_mode)
            M_RUN:   return m_idx + 1;
            M_PAUSE: return 9;
            M_HALT:  return 10;
            default: return 0;
        endcase
    endfunction

    function automatic logic [28:0] exp_vec();
        if (m_mode != M_RUN) return '0;
        if (m_idx < 3) return fet[m_idx];
        return tbl[cls_of(ir)][m_idx - 3];
    endfunction

    function automatic int exp_alu();
        if (m_mode == M_RUN && m_idx == 4 && cls_of(ir) == C_ALU) return int'(ir) - 3;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (cmp_en) begin
            chk("step", int'(step), exp_step());
            chk("Run", int'(Run), (m_mode == M_RUN) ? 1 : 0);
            chk("ALUsel", int'(ALUsel), exp_alu());
            chk("strobes", int'(act_vec), int'(exp_vec()));
            chk("bus_onehot0", $onehot0({PCout, ZLowout, ZHighout, MDRout, HIout, LOout,
                                         Cout, InPortOut, BAout, Rout}) ? 1 : 0, 1);
        end
    end

    task automatic wait_step(input int s);
        for (int n = 0; n < 400; n++) begin
            @(posedge Clock);
            #1;
            if (exp_step() == s) return;
        end
        chk("timeout_step", exp_step(), s);
    endtask

    task automatic wait_for(input logic [4:0] op, input int s);
        for (int n = 0; n < 400; n++) begin
            @(posedge Clock);
            #1;
            if (ir == op && exp_step() == s) return;
        end
        chk("timeout_op", exp_step(), s);
    endtask

    function automatic logic [4:0] rand_op();
        logic [4:0] lst [0:8];
        logic [4:0] r;
        int         k;
        lst = '{LD, LDI, ST, ADD, SUB, AND_OP, OR_OP, IN_OP, OUT_OP};
        k = $urandom_range(0, 11);
        if (k <= 8) return lst[k];
        if (k == 9) return NOP;
        if (k == 11 && $urandom_range(0, 3) == 0) return HALT;
        r = 5'($urandom);
        return (r == HALT) ? NOP : r;
    endfunction

    initial begin
        for (int c = 0; c < 7; c++)
            for (int k = 0; k < 5; k++)
                tbl[c][k] = '0;
        fet[0] = PCOUT | MARIN | INCPC | ZLOWIN;
        fet[1] = ZLOWOUT | PCIN | READ | MDRIN;
        fet[2] = MDROUT | IRIN;
        tbl[C_LD][0] = GRB_M | BAOUT | YIN;
        tbl[C_LD][1] = COUT | ZLOWIN;
        tbl[C_LD][2] = ZLOWOUT | MARIN;
        tbl[C_LD][3] = READ | MDRIN;
        tbl[C_LD][4] = MDROUT | GRA_M | RIN;
        tbl[C_LDI][0] = tbl[C_LD][0];
        tbl[C_LDI][1] = tbl[C_LD][1];
        tbl[C_LDI][2] = ZLOWOUT | GRA_M | RIN;
        tbl[C_ST][0] = tbl[C_LD][0];
        tbl[C_ST][1] = tbl[C_LD][1];
        tbl[C_ST][2] = tbl[C_LD][2];
        tbl[C_ST][3] = GRA_M | ROUT | MDRIN;
        tbl[C_ST][4] = MDROUT | RAMIN;
        tbl[C_ALU][0] = GRB_M | ROUT | YIN;
        tbl[C_ALU][1] = GRC_M | ROUT | ZLOWIN;
        tbl[C_ALU][2] = ZLOWOUT | GRA_M | RIN;
        tbl[C_IN][0]  = INPORTOUT | GRA_M | RIN;
        tbl[C_OUT][0] = GRA_M | ROUT | OUTPORTIN;

        // Power-on reset
        #2 Clear = 1'b0;
        cmp_en = 1'b1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        chk("rst_step", int'(step), 0);
        chk("rst_strobes", int'({act_vec, ALUsel, Run}), 0);
        @(posedge Clock); #1 Clear = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        chk("t0_step", int'(step), 1);
        chk("t0_strobes", int'({PCout, MARin, IncPC, ZLowIn}), 4'hF);

        // Abort ld in T4 with a 3-cycle Clear
        q.push_back(LD);
        wait_for(LD, 5);
        Clear = 1'b0;
        @(negedge Clock);
        chk("abort_step", int'(step), 0);
        chk("abort_strobes", int'(act_vec), 0);
        repeat (3) @(posedge Clock);
        #1 Clear = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        chk("restart_step", int'(step), 1);

        // ld, st, ALU ops, in/out, unknown opcode
        q.push_back(LD);
        wait_for(LD, 8);
        @(negedge Clock);
        chk("ld_t7", int'({MDRout, GRA, Rin, Read}), 4'b1110);
        q.push_back(ST);
        wait_for(ST, 7);
        @(negedge Clock);
        chk("st_t6", int'({GRA, Rout, MDRin, Read}), 4'b1110);
        q.push_back(SUB);
        wait_for(SUB, 5);
        @(negedge Clock);
        chk("sub_t4_alu", int'(ALUsel), 1);
        chk("sub_t4_grc", int'({GRC, Rout, ZLowIn}), 3'b111);
        q.push_back(AND_OP);
        q.push_back(OR_OP);
        q.push_back(IN_OP);
        q.push_back(OUT_OP);
        q.push_back(5'b11111);
        wait_for(OR_OP, 5);
        @(negedge Clock);
        chk("or_t4_alu", int'(ALUsel), 3);
        wait_for(5'b11111, 4);

        // Stop during add: completes, then pauses
        q.push_back(ADD);
        wait_for(ADD, 4);
        Stop = 1'b1;
        wait_step(9);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            chk("pause_step", int'(step), 9);
        end
        @(posedge Clock); #1 Stop = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        chk("unpause_step", int'(step), 1);

        // halt absorbs, Stop ignored, Clear restarts
        q.push_back(HALT);
        wait_step(10);
        Stop = 1'b1;
        repeat (20) @(posedge Clock);
        @(negedge Clock);
        chk("halt_run", int'({Run, step}), 5'h0A);
        #1 Stop = 1'b0;
        @(posedge Clock); #1 Clear = 1'b0;
        @(posedge Clock); #1 Clear = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        chk("halt_restart", int'(step), 1);

        // Randomized traffic with Stop and occasional Clear pulses
        for (int n = 0; n < 4000; n++) begin
            @(posedge Clock);
            #1;
            if (q.size() < 2) q.push_back(rand_op());
            Stop  = ($urandom_range(0, 9) == 0);
            Clear = ($urandom_range(0, 299) != 0);
        end
        Clear = 1'b1;
        Stop  = 1'b0;
        repeat (10) @(posedge Clock);
        @(negedge Clock);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the single-bus CPU datapath. Walks the datapath through instruction fetch (T0–T2) and per-opcode execute steps (T3–T7) as a one-state-per-clock FSM, and drives every datapath strobe from the current step and the IR opcode. It sits beside the datapath and replaces hand-scripted control sequences. It also provides pause (Stop) and halt handling.

## Interface
- No parameters.
- Clock  in  1  system clock; all state changes on rising edge.
- Clear  in  1  asynchronous active-low reset.
- opcode  in  5  IR[31:27] from datapath; stable except when IRin captures.
- Stop  in  1  pause request, sampled at instruction boundary.
- PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortOut, BAout, Rout  out  1 each  bus-drive strobes.
- MARin, MDRin, PCin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, CONin, Rin, RAMin, OutPortIn, InPortIn  out  1 each  register-load strobes.
- IncPC, Read, GRA, GRB, GRC  out  1 each  PC increment, memory read, register-field selects.
- ALUsel  out  4  ALU function: 0 ADD, 1 SUB, 2 AND, 3 OR; 0 when unused.
- Run  out  1  high while sequencing instructions.
- step  out  4  current state code (debug).

## Operation
- States and codes: RST=0, T0..T7=1..8, PAUSE=9, HALT=10.
- Outputs are a combinational decode of the state register and live `opcode`. Outputs not listed for a step are 0.
- Fetch sequence:
  - T0: PCout, MARin, IncPC, ZLowIn.
  - T1: ZLowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Opcode map (5-bit): ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, in 10110, out 10111, nop 11000, halt 11001. Any other value executes as nop.
- ld:
  - T3: GRB, BAout, Yin.
  - T4: Cout, ALUsel=0, ZLowIn.
  - T5: ZLowout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, GRA, Rin.
- ldi: T3/T4 as ld; T5: ZLowout, GRA, Rin.
- st: T3–T5 as ld.
  - T6: GRA, Rout, MDRin (Read=0).
  - T7: MDRout, RAMin.
- add/sub/and/or:
  - T3: GRB, Rout, Yin.
  - T4: GRC, Rout, ALUsel per opcode, ZLowIn.
  - T5: ZLowout, GRA, Rin.
- in: T3: InPortOut, GRA, Rin.
- out: T3: GRA, Rout, OutPortIn.
- nop: T3 drives nothing.
- halt: T3 drives nothing; next state HALT.
- Last step per class: T7 for ld/st, T5 for ldi/ALU, T3 for in/out/nop.
- From the last step, the next state is PAUSE if Stop=1, else T0.
- PAUSE → T0 on the first edge with Stop=0. All strobes 0 in PAUSE.
- HALT is absorbing; only Clear leaves it. All strobes 0, Run=0.
- Run=1 in T0..T7, 0 in RST/PAUSE/HALT.

## Timing
- Clear low: state=RST immediately (asynchronous). All strobes, ALUsel and Run are 0; step=0.
- First rising edge after Clear deasserts: RST→T0. Clear is released synchronously by upstream logic.
- Clear asserted mid-instruction aborts at once; no partial strobes after assertion.
- Instruction length in cycles: ld 8, st 8, ldi 6, ALU 6, in/out/nop 4, halt 4 then stop.
- Exactly one register-load strobe target per bus transfer. Bus-drive strobes are mutually exclusive in every state (checked by assertion).
- `opcode` is only consulted in T3..T7. In T0–T2 decode ignores it, because IR changes at the end of T2.
- Stop asserted mid-instruction has no effect until the last step. Stop=1 held in PAUSE keeps PAUSE indefinitely.
- Stop and halt together: HALT wins.

## Test plan
- Reset: Clear=0 for 3 cycles mid-T4 of ld, then release → all outputs 0 during reset; step=1 (T0) one edge after release, PCout=MARin=IncPC=ZLowIn=1.
- ld (opcode 00000): step sequence 1..8 then 1. Read=1 only in T1 and T6; GRA+Rin only in T7; total 8 cycles.
- st (00010): T6 shows GRA/Rout/MDRin with Read=0; RAMin=1 only in T7; no Rin at any step.
- sub (00100): ALUsel=1 exactly in T4 with GRC/Rout/ZLowIn; returns to T0 after T5 (6 cycles). Repeat for and/or with ALUsel 2/3.
- in then out (10110, 10111): InPortOut/GRA/Rin in T3, then OutPortIn/GRA/Rout in the next T3. Each instruction is 4 cycles.
- Stop held high from T2 of add → T3..T5 complete, then PAUSE (step=9, Run=0) for 5 cycles. Drop Stop → T0 next edge.
- halt (11001) → HALT after T3, Run=0 for 20 cycles, Stop ignored. Clear pulse → T0 restart.
- Opcode 11111 → behaves as nop, 4 cycles.
